ofs_plat_axi_mem_if_desync: RTL and testbench



---
 rtl/ofs_plat_axi_mem_if_desync_pkg.sv | 13 +
 rtl/ofs_plat_axi_mem_pkg.sv | 38 +++
 rtl/ofs_plat_axi_mem_if.sv | 35 +++
 rtl/ofs_plat_axi_mem_desync_aw_fifo.sv | 72 +++++++
 rtl/ofs_plat_axi_mem_if_desync.sv | 87 ++++++++
 tb/tb_ofs_plat_axi_mem_if_desync.sv | 309 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/ofs_plat_axi_mem_if_desync_pkg.sv
// Shared constants and helpers for the AW/W desync block; no new channel types.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package ofs_plat_axi_mem_if_desync_pkg;

   localparam int AW_FIFO_DEPTH_DEFAULT = 4;

   // Occupancy counter must represent 0..depth inclusive.
   function automatic int aw_cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/ofs_plat_axi_mem_pkg.sv
// AXI memory channel payload types shared by every ofs_plat_axi_mem_if instance.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package ofs_plat_axi_mem_pkg;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
   } t_axi_aw;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  strb;
      logic        last;
   } t_axi_w;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } t_axi_b;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
   } t_axi_ar;

   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
   } t_axi_r;

endpackage

// File: rtl/ofs_plat_axi_mem_if.sv
// AXI memory interface: five channels, each with valid/ready and a packed payload.
// Latency: n/a (wires only).
// Backpressure: standard AXI valid/ready per channel.
// Modports: to_source = the module faces a master (receives AW/W/AR, returns B/R);
//           to_sink   = the module faces a slave  (drives AW/W/AR, receives B/R).
interface ofs_plat_axi_mem_if;
   import ofs_plat_axi_mem_pkg::*;

   logic    awvalid;
   logic    awready;
   t_axi_aw aw;
   logic    wvalid;
   logic    wready;
   t_axi_w  w;
   logic    bvalid;
   logic    bready;
   t_axi_b  b;
   logic    arvalid;
   logic    arready;
   t_axi_ar ar;
   logic    rvalid;
   logic    rready;
   t_axi_r  r;

   modport to_source (
      input  awvalid, aw, wvalid, w, bready, arvalid, ar, rready,
      output awready, wready, bvalid, b, arready, rvalid, r
   );

   modport to_sink (
      output awvalid, aw, wvalid, w, bready, arvalid, ar, rready,
      input  awready, wready, bvalid, b, arready, rvalid, r
   );

endinterface

// File: rtl/ofs_plat_axi_mem_desync_aw_fifo.sv
// Small AW address FIFO: counter-tracked, registered full flag, unreset storage.
// Latency: an entry written in cycle N is visible at the head in cycle N+1.
// Backpressure: enq ignored while full (even on a same-cycle deq); deq ignored while empty.
// Ports: clk, reset_n (async, active-low); enq_en/enq_data push; deq_en pop;
//        first = head entry, not_empty, full (registered), cnt = occupancy.
module ofs_plat_axi_mem_desync_aw_fifo #(
   parameter int DEPTH      = 4,   // power of 2, at least 2
   parameter int DATA_WIDTH = 8
)(
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         enq_en,
   input  logic [DATA_WIDTH-1:0]        enq_data,
   input  logic                         deq_en,
   output logic [DATA_WIDTH-1:0]        first,
   output logic                         not_empty,
   output logic                         full,
   output logic [$clog2(DEPTH+1)-1:0]   cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         cnt_nxt;
   logic                  do_enq;
   logic                  do_deq;

   // Full is registered, so a pop cannot open a slot for a push in the same
   // cycle; this keeps the sink's awready off the source's ready path.
   assign do_enq    = enq_en && !full;
   assign do_deq    = deq_en && not_empty;
   assign not_empty = (cnt != '0);
   assign first     = mem[rd_ptr];

   always_comb begin
      cnt_nxt = cnt;
      if (do_enq && !do_deq) begin
         cnt_nxt = cnt + 1'b1;
      end else if (!do_enq && do_deq) begin
         cnt_nxt = cnt - 1'b1;
      end
   end

   // DEPTH is a power of 2, so pointer overflow is the modulo-DEPTH wrap.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         full   <= 1'b0;
      end else begin
         cnt  <= cnt_nxt;
         full <= (cnt_nxt == CW'(DEPTH));
         if (do_enq) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_deq) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_enq) begin
         mem[wr_ptr] <= enq_data;
      end
   end

endmodule

// File: rtl/ofs_plat_axi_mem_if_desync.sv
// Splits a synchronized AW+first-W write stream into independent AXI AW and W channels.
// Latency: W 0 cycles (combinational); AW >= 1 cycle through the AW FIFO; AR/R/B 0 cycles.
// Backpressure: SOP beats need AW FIFO space and sink wready together; later beats follow sink wready.
// Ports: clk, reset_n (async, active-low); mem_source = synchronized producer side;
//        mem_sink = decoupled AXI memory side.
module ofs_plat_axi_mem_if_desync
   import ofs_plat_axi_mem_pkg::*;
   import ofs_plat_axi_mem_if_desync_pkg::*;
#(
   parameter int AW_FIFO_DEPTH = AW_FIFO_DEPTH_DEFAULT
)(
   input  logic                   clk,
   input  logic                   reset_n,
   ofs_plat_axi_mem_if.to_source  mem_source,
   ofs_plat_axi_mem_if.to_sink    mem_sink
);

   localparam int AW_W = $bits(t_axi_aw);

   logic                                     wr_is_sop;
   logic                                     sop_go;
   logic                                     aw_push;
   logic                                     aw_pop;
   logic                                     aw_full;
   logic                                     aw_not_empty;
   logic [aw_cnt_width(AW_FIFO_DEPTH)-1:0]   aw_cnt;
   logic [AW_W-1:0]                          aw_head;

   // At SOP the address and first data beat move together: both need FIFO
   // space, sink wready and both source valids. The sink's awready is never
   // involved, because aw_full is a registered flag.
   assign sop_go = !aw_full && mem_sink.wready &&
                   mem_source.awvalid && mem_source.wvalid;

   // reset_n gating keeps awready low while the block is held in reset.
   assign mem_source.awready = wr_is_sop && sop_go && reset_n;
   assign mem_source.wready  = wr_is_sop ? sop_go : mem_sink.wready;

   assign mem_sink.w      = mem_source.w;
   assign mem_sink.wvalid = mem_source.wvalid &&
                            (wr_is_sop ? (mem_source.awvalid && !aw_full) : 1'b1);

   assign aw_push = mem_source.awvalid && mem_source.awready;
   assign aw_pop  = mem_sink.awvalid && mem_sink.awready;

   // The beat after a 'last' beat starts the next burst.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_is_sop <= 1'b1;
      end else if (mem_source.wvalid && mem_source.wready) begin
         wr_is_sop <= mem_source.w.last;
      end
   end

   ofs_plat_axi_mem_desync_aw_fifo #(
      .DEPTH      (AW_FIFO_DEPTH),
      .DATA_WIDTH (AW_W)
   ) aw_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .enq_en    (aw_push),
      .enq_data  (mem_source.aw),
      .deq_en    (aw_pop),
      .first     (aw_head),
      .not_empty (aw_not_empty),
      .full      (aw_full),
      .cnt       (aw_cnt)
   );

   // The head is held until popped, so awvalid/aw stay stable until accepted.
   assign mem_sink.awvalid = aw_not_empty;
   assign mem_sink.aw      = aw_head;

   // Read address, read data and write response are straight wires.
   assign mem_sink.arvalid   = mem_source.arvalid;
   assign mem_sink.ar        = mem_source.ar;
   assign mem_source.arready = mem_sink.arready;

   assign mem_source.rvalid  = mem_sink.rvalid;
   assign mem_source.r       = mem_sink.r;
   assign mem_sink.rready    = mem_source.rready;

   assign mem_source.bvalid  = mem_sink.bvalid;
   assign mem_source.b       = mem_sink.b;
   assign mem_sink.bready    = mem_source.bready;

endmodule

// File: tb/tb_ofs_plat_axi_mem_if_desync.sv
// Testbench for ofs_plat_axi_mem_if_desync: vector table, directed corner cases,
// and a randomized burst stream checked against a queue-based reference model.
module tb_ofs_plat_axi_mem_if_desync;
   import ofs_plat_axi_mem_pkg::*;

   localparam int DEPTH = 4;
   localparam int NB    = 80;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   logic clk_en  = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   ofs_plat_axi_mem_if src_if();
   ofs_plat_axi_mem_if snk_if();

   ofs_plat_axi_mem_if_desync #(.AW_FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .mem_source (src_if),
      .mem_sink   (snk_if)
   );

   initial begin
      forever begin
         #5;
         if (clk_en) clk = ~clk;
      end
   end

   // {inputs} -> expected {src awready, src wready, sink wvalid, sink awvalid}
   typedef struct {
      logic       awv;
      logic       wv;
      logic       swr;
      logic       sawr;
      logic [3:0] exp;
   } vec_t;
   vec_t vt[8];

   // Reference model state for the random stream.
   t_axi_aw  b_aw[NB];
   int       b_len[NB];
   t_axi_aw  q[$];
   bit       m_sop;
   int       bi, beat, aw_idx, cyc;
   bit       aw_v, w_v, e_awr, e_wr, e_swv, e_kav, full;
   t_axi_w   cur_w;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      src_if.awvalid = 1'b0; src_if.aw = '0; src_if.wvalid = 1'b0; src_if.w = '0;
      src_if.bready  = 1'b0; src_if.arvalid = 1'b0; src_if.ar = '0; src_if.rready = 1'b0;
      snk_if.awready = 1'b0; snk_if.wready = 1'b0; snk_if.bvalid = 1'b0; snk_if.b = '0;
      snk_if.arready = 1'b0; snk_if.rvalid = 1'b0; snk_if.r = '0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset_n = 1'b0;
      drive_idle();
      @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      vt[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'b1110};
      vt[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'b1110};
      vt[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'b0010};
      vt[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'b0000};
      vt[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b0000};
      vt[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'b0000};
      vt[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};
      vt[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0000};

      drive_idle();
      #12;
      // Reset state, with source valids up while held in reset.
      src_if.awvalid = 1'b1; src_if.wvalid = 1'b1; src_if.w.last = 1'b1; snk_if.wready = 1'b1;
      #1;
      check("rst_aw_cnt", dut.aw_cnt, 0);
      check("rst_sink_awvalid", snk_if.awvalid, 0);
      check("rst_src_awready", src_if.awready, 0);
      check("rst_sink_wvalid", snk_if.wvalid, 1);
      drive_idle();
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Vector table at SOP with an empty FIFO; clock frozen so nothing is consumed.
      clk_en = 1'b0;
      #20;
      for (int i = 0; i < 8; i++) begin
         src_if.awvalid = vt[i].awv; src_if.wvalid = vt[i].wv;
         snk_if.wready = vt[i].swr; snk_if.awready = vt[i].sawr;
         #2;
         check($sformatf("vec%0d", i),
               {src_if.awready, src_if.wready, snk_if.wvalid, snk_if.awvalid}, vt[i].exp);
      end
      drive_idle();
      clk_en = 1'b1;

      // Single beat, sink always ready.
      do_reset();
      src_if.aw.addr = 32'h1000; src_if.aw.id = 4'd1; src_if.awvalid = 1'b1;
      src_if.wvalid = 1'b1; src_if.w.last = 1'b1; src_if.w.data = 64'hA5;
      snk_if.wready = 1'b1; snk_if.awready = 1'b1;
      @(negedge clk);
      check("t1_src_awready", src_if.awready, 1);
      check("t1_src_wready", src_if.wready, 1);
      check("t1_sink_wvalid", snk_if.wvalid, 1);
      check("t1_sink_wdata", snk_if.w.data, 64'hA5);
      check("t1_sink_awvalid_c0", snk_if.awvalid, 0);
      step();
      src_if.awvalid = 1'b0; src_if.wvalid = 1'b0;
      @(negedge clk);
      check("t1_sink_awvalid_c1", snk_if.awvalid, 1);
      check("t1_sink_awaddr", snk_if.aw.addr, 32'h1000);
      step();
      @(negedge clk);
      check("t1_sink_awvalid_c2", snk_if.awvalid, 0);

      // 4-beat burst, sink W ready, AW held back.
      do_reset();
      snk_if.wready = 1'b1; snk_if.awready = 1'b0;
      src_if.aw.addr = 32'h2000; src_if.aw.len = 8'd3; src_if.awvalid = 1'b1; src_if.wvalid = 1'b1;
      for (int b = 0; b < 4; b++) begin
         src_if.w.data = 64'(b + 16); src_if.w.last = (b == 3);
         if (b > 0) src_if.awvalid = 1'b0;
         @(negedge clk);
         check($sformatf("t2_sink_wvalid_b%0d", b), snk_if.wvalid, 1);
         check($sformatf("t2_sink_wdata_b%0d", b), snk_if.w.data, 64'(b + 16));
         check($sformatf("t2_src_wready_b%0d", b), src_if.wready, 1);
         if (b > 0) check($sformatf("t2_aw_cnt_b%0d", b), dut.aw_cnt, 1);
         step();
      end
      src_if.wvalid = 1'b0;
      @(negedge clk);
      check("t2_aw_cnt_wait", dut.aw_cnt, 1);
      check("t2_sink_awvalid_wait", snk_if.awvalid, 1);
      step();
      snk_if.awready = 1'b1;
      @(negedge clk);
      check("t2_sink_awaddr", snk_if.aw.addr, 32'h2000);
      step();
      @(negedge clk);
      check("t2_aw_cnt_drained", dut.aw_cnt, 0);

      // Backpressure to full with DEPTH single-beat writes queued.
      do_reset();
      snk_if.wready = 1'b1; snk_if.awready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         src_if.awvalid = 1'b1; src_if.wvalid = 1'b1; src_if.w.last = 1'b1;
         src_if.aw.addr = 32'h3000 + 32'(k * 64);
         @(negedge clk);
         check($sformatf("t3_awready_w%0d", k), src_if.awready, (k < 4));
         check($sformatf("t3_wready_w%0d", k), src_if.wready, (k < 4));
         step();
      end
      snk_if.awready = 1'b1;
      @(negedge clk);
      check("t3_aw_cnt_full", dut.aw_cnt, 4);
      check("t3_awready_during_pop", src_if.awready, 0);
      check("t3_sink_awaddr_head", snk_if.aw.addr, 32'h3000);
      step();
      snk_if.awready = 1'b0;
      @(negedge clk);
      check("t3_aw_cnt_after_pop", dut.aw_cnt, 3);
      check("t3_awready_after_pop", src_if.awready, 1);
      step();
      drive_idle();
      @(negedge clk);
      check("t3_aw_cnt_refill", dut.aw_cnt, 4);

      // Sink wready low at SOP with AW valid.
      do_reset();
      src_if.awvalid = 1'b1; src_if.wvalid = 1'b1; src_if.w.last = 1'b1; src_if.aw.addr = 32'h4000;
      snk_if.wready = 1'b0;
      @(negedge clk);
      check("t4_awready_stall", src_if.awready, 0);
      check("t4_wready_stall", src_if.wready, 0);
      step();
      @(negedge clk);
      check("t4_aw_cnt_stall", dut.aw_cnt, 0);
      step();
      snk_if.wready = 1'b1;
      @(negedge clk);
      check("t4_awready_go", src_if.awready, 1);
      check("t4_wready_go", src_if.wready, 1);
      step();
      drive_idle();
      @(negedge clk);
      check("t4_aw_cnt_go", dut.aw_cnt, 1);

      // Asynchronous reset during beat 2 of a 4-beat burst.
      do_reset();
      snk_if.wready = 1'b1;
      src_if.aw.addr = 32'h5000; src_if.awvalid = 1'b1; src_if.wvalid = 1'b1; src_if.w.last = 1'b0;
      step();
      src_if.awvalid = 1'b0;
      step();
      @(negedge clk);
      check("t5_aw_cnt_before", dut.aw_cnt, 1);
      #1;
      reset_n = 1'b0;
      src_if.awvalid = 1'b1;
      #1;
      check("t5_aw_cnt_rst", dut.aw_cnt, 0);
      check("t5_sink_awvalid_rst", snk_if.awvalid, 0);
      check("t5_src_awready_rst", src_if.awready, 0);
      step();
      reset_n = 1'b1;
      src_if.aw.addr = 32'h5100; src_if.w.last = 1'b1;
      @(negedge clk);
      check("t5_sop_awready", src_if.awready, 1);
      check("t5_sop_wready", src_if.wready, 1);
      step();
      src_if.awvalid = 1'b0; src_if.wvalid = 1'b0;
      @(negedge clk);
      check("t5_aw_cnt_after", dut.aw_cnt, 1);
      check("t5_sink_awaddr", snk_if.aw.addr, 32'h5100);

      // AR/R/B pass-through.
      do_reset();
      src_if.arvalid = 1'b1; src_if.ar.id = 4'd3; src_if.ar.addr = 32'h6000; snk_if.arready = 1'b1;
      snk_if.bvalid = 1'b1; snk_if.b.resp = 2'd2; snk_if.b.id = 4'd5; src_if.bready = 1'b0;
      snk_if.rvalid = 1'b1; snk_if.r.data = 64'hDEAD_BEEF; src_if.rready = 1'b1;
      @(negedge clk);
      check("t6_sink_arvalid", snk_if.arvalid, 1);
      check("t6_sink_ar_id", snk_if.ar.id, 3);
      check("t6_src_arready", src_if.arready, 1);
      check("t6_src_bvalid", src_if.bvalid, 1);
      check("t6_src_bresp", src_if.b.resp, 2);
      check("t6_sink_bready", snk_if.bready, 0);
      check("t6_src_rdata", src_if.r.data, 64'hDEAD_BEEF);
      check("t6_sink_rready", snk_if.rready, 1);

      // Randomized burst stream against a queue model of the AW FIFO.
      for (int i = 0; i < NB; i++) begin
         b_len[i]       = $urandom_range(1, 4);
         b_aw[i].id     = 4'($urandom);
         b_aw[i].addr   = $urandom;
         b_aw[i].len    = 8'(b_len[i] - 1);
         b_aw[i].size   = 3'd3;
      end
      do_reset();
      q.delete();
      m_sop = 1'b1; bi = 0; beat = 0; aw_idx = 0; cyc = 0; aw_v = 1'b0; w_v = 1'b0;
      while ((bi < NB || q.size() != 0) && cyc < 5000) begin
         cyc++;
         if (!aw_v && aw_idx < NB) aw_v = ($urandom_range(0, 3) != 0);
         if (!w_v && bi < NB)      w_v  = ($urandom_range(0, 3) != 0);
         cur_w.data = {32'(bi), 32'(beat)};
         cur_w.strb = 8'hFF;
         cur_w.last = (bi < NB) && (beat == b_len[bi] - 1);
         src_if.awvalid = aw_v;
         src_if.aw      = (aw_idx < NB) ? b_aw[aw_idx] : '0;
         src_if.wvalid  = w_v;
         src_if.w       = cur_w;
         snk_if.wready  = ($urandom_range(0, 3) != 0);
         snk_if.awready = ($urandom_range(0, 1) != 0);
         @(negedge clk);
         full  = (q.size() == DEPTH);
         e_awr = m_sop && !full && snk_if.wready && aw_v && w_v;
         e_wr  = m_sop ? e_awr : snk_if.wready;
         e_swv = w_v && (m_sop ? (aw_v && !full) : 1'b1);
         e_kav = (q.size() != 0);
         check("rnd_ready_valid", {src_if.awready, src_if.wready, snk_if.wvalid, snk_if.awvalid},
               {e_awr, e_wr, e_swv, e_kav});
         check("rnd_aw_cnt", dut.aw_cnt, q.size());
         if (e_kav) check("rnd_sink_aw", snk_if.aw, q[0]);
         if (e_swv) check("rnd_sink_w", snk_if.w, cur_w);
         @(posedge clk);
         if (e_kav && snk_if.awready) void'(q.pop_front());
         if (aw_v && e_awr) begin
            q.push_back(b_aw[aw_idx]);
            aw_idx++;
            aw_v = 1'b0;
         end
         if (w_v && e_wr) begin
            m_sop = cur_w.last;
            w_v = 1'b0;
            if (cur_w.last) begin
               bi++;
               beat = 0;
            end else begin
               beat++;
            end
         end
         #1;
      end
      check("rnd_all_drained", {bi == NB, q.size() == 0}, 2'b11);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
